// File: rtl/decode_pkg.sv
// Shared constants for the pipelined decode stage: register index width,
// destination-select encodings and instruction field positions.
package decode_pkg;

  localparam int unsigned REG_AW = 3;

  localparam logic [1:0] RD_RT   = 2'b00;  // instr[7:5]
  localparam logic [1:0] RD_RS   = 2'b01;  // instr[10:8]
  localparam logic [1:0] RD_RD   = 2'b10;  // instr[4:2]
  localparam logic [1:0] RD_LINK = 2'b11;

  localparam int unsigned RS1_LSB   = 8;
  localparam int unsigned RS2_LSB   = 5;
  localparam int unsigned RD_LSB    = 2;
  localparam int unsigned IMM5_MSB  = 4;
  localparam int unsigned IMM8_MSB  = 7;
  localparam int unsigned IMM11_MSB = 10;

endpackage

// File: rtl/decode_regfile.sv
// Eight-entry register file, two combinational read ports, one write port,
// with optional same-cycle write-to-read forwarding.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wsel_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] regs_q [2**REG_AW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2**REG_AW; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[wsel_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (BYPASS && we_i && (wsel_i == raddr1_i)) rdata1_o = wdata_i;
    if (BYPASS && we_i && (wsel_i == raddr2_i)) rdata2_o = wdata_i;
  end

endmodule

// File: rtl/decode_pipe.sv
// Pipelined decode stage: IF/ID register, register file, load-use interlock,
// flush handling and the ID/EX register.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned LINK_REG = 7,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc2,
  input  logic              flush,
  output logic [15:0]       id_instr,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_regwrt,
  input  logic              id_is_load,
  input  logic              id_zext,
  input  logic [1:0]        id_rd_dst,
  input  logic              wb_en,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [15:0]       ex_instr,
  output logic [DATA_W-1:0] ex_pc2,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [2:0]        ex_wsel,
  output logic              ex_regwrt,
  output logic              ex_is_load,
  output logic [DATA_W-1:0] ex_imm5,
  output logic [DATA_W-1:0] ex_imm8,
  output logic [DATA_W-1:0] ex_imm11
);

  if (NUM_REGS != 8 || DATA_W < 16) begin : g_bad_params
    $error("decode_pipe: NUM_REGS must be 8 and DATA_W must be >= 16");
  end

  localparam logic [REG_AW-1:0] LinkSel = REG_AW'(LINK_REG);

  logic              id_valid_q;
  logic [15:0]       id_instr_q;
  logic [DATA_W-1:0] id_pc2_q;

  logic              ex_valid_q, ex_regwrt_q, ex_is_load_q;
  logic [15:0]       ex_instr_q;
  logic [DATA_W-1:0] ex_pc2_q, ex_rd1_q, ex_rd2_q, ex_imm5_q, ex_imm8_q, ex_imm11_q;
  logic [2:0]        ex_wsel_q;

  logic [REG_AW-1:0] rs1, rs2, wsel_d;
  logic [DATA_W-1:0] rd1, rd2, imm5_d, imm8_d, imm11_d;
  logic              bubble;

  assign rs1 = id_instr_q[RS1_LSB +: REG_AW];
  assign rs2 = id_instr_q[RS2_LSB +: REG_AW];

  decode_regfile #(
    .DATA_W (DATA_W),
    .BYPASS (BYPASS)
  ) u_regfile (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (wb_en),
    .wsel_i   (wb_sel),
    .wdata_i  (wb_data),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  // The bubble clears ex_is_load, so a stall never lasts more than one cycle.
  assign stall = id_valid_q & ex_valid_q & ex_is_load_q & ex_regwrt_q &
                 ((id_use_rs1 & (ex_wsel_q == rs1)) | (id_use_rs2 & (ex_wsel_q == rs2)));
  assign bubble = flush | stall;

  always_comb begin
    wsel_d = id_instr_q[RS2_LSB +: REG_AW];
    unique case (id_rd_dst)
      RD_RT:   wsel_d = id_instr_q[RS2_LSB +: REG_AW];
      RD_RS:   wsel_d = id_instr_q[RS1_LSB +: REG_AW];
      RD_RD:   wsel_d = id_instr_q[RD_LSB +: REG_AW];
      RD_LINK: wsel_d = LinkSel;
      default: wsel_d = id_instr_q[RS2_LSB +: REG_AW];
    endcase
  end

  always_comb begin
    imm5_d  = id_zext ? DATA_W'(id_instr_q[IMM5_MSB:0])
                      : {{(DATA_W-5){id_instr_q[IMM5_MSB]}}, id_instr_q[IMM5_MSB:0]};
    imm8_d  = id_zext ? DATA_W'(id_instr_q[IMM8_MSB:0])
                      : {{(DATA_W-8){id_instr_q[IMM8_MSB]}}, id_instr_q[IMM8_MSB:0]};
    imm11_d = {{(DATA_W-11){id_instr_q[IMM11_MSB]}}, id_instr_q[IMM11_MSB:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_pc2_q     <= '0;
      ex_valid_q   <= 1'b0;
      ex_regwrt_q  <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_instr_q   <= '0;
      ex_pc2_q     <= '0;
      ex_rd1_q     <= '0;
      ex_rd2_q     <= '0;
      ex_wsel_q    <= '0;
      ex_imm5_q    <= '0;
      ex_imm8_q    <= '0;
      ex_imm11_q   <= '0;
    end else begin
      if (flush) begin
        id_valid_q <= 1'b0;
      end else if (!stall) begin
        id_valid_q <= if_valid;
        id_instr_q <= if_instr;
        id_pc2_q   <= if_pc2;
      end

      if (bubble) begin
        ex_valid_q   <= 1'b0;
        ex_regwrt_q  <= 1'b0;
        ex_is_load_q <= 1'b0;
        ex_instr_q   <= '0;
        ex_pc2_q     <= '0;
        ex_rd1_q     <= '0;
        ex_rd2_q     <= '0;
        ex_wsel_q    <= '0;
        ex_imm5_q    <= '0;
        ex_imm8_q    <= '0;
        ex_imm11_q   <= '0;
      end else begin
        ex_valid_q   <= id_valid_q;
        ex_regwrt_q  <= id_valid_q & id_regwrt;
        ex_is_load_q <= id_valid_q & id_is_load;
        ex_instr_q   <= id_instr_q;
        ex_pc2_q     <= id_pc2_q;
        ex_rd1_q     <= rd1;
        ex_rd2_q     <= rd2;
        ex_wsel_q    <= wsel_d;
        ex_imm5_q    <= imm5_d;
        ex_imm8_q    <= imm8_d;
        ex_imm11_q   <= imm11_d;
      end
    end
  end

  assign id_instr   = id_instr_q;
  assign ex_valid   = ex_valid_q;
  assign ex_instr   = ex_instr_q;
  assign ex_pc2     = ex_pc2_q;
  assign ex_rd1     = ex_rd1_q;
  assign ex_rd2     = ex_rd2_q;
  assign ex_wsel    = ex_wsel_q;
  assign ex_regwrt  = ex_regwrt_q;
  assign ex_is_load = ex_is_load_q;
  assign ex_imm5    = ex_imm5_q;
  assign ex_imm8    = ex_imm8_q;
  assign ex_imm11   = ex_imm11_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe; a second instance with BYPASS=0 checks the
// non-forwarding register read.
module tb_decode_pipe;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_valid = 1'b0, flush = 1'b0;
  logic [15:0]   if_instr = '0;
  logic [DW-1:0] if_pc2 = '0;
  logic          id_use_rs1 = 0, id_use_rs2 = 0, id_regwrt = 0, id_is_load = 0, id_zext = 0;
  logic [1:0]    id_rd_dst = '0;
  logic          wb_en = 1'b0;
  logic [2:0]    wb_sel = '0;
  logic [DW-1:0] wb_data = '0;

  logic [15:0]   id_instr, ex_instr, nb_id_instr, nb_ex_instr;
  logic          stall, ex_valid, ex_regwrt, ex_is_load;
  logic          nb_stall, nb_ex_valid, nb_ex_regwrt, nb_ex_is_load;
  logic [DW-1:0] ex_pc2, ex_rd1, ex_rd2, ex_imm5, ex_imm8, ex_imm11;
  logic [DW-1:0] nb_ex_pc2, nb_ex_rd1, nb_ex_rd2, nb_ex_imm5, nb_ex_imm8, nb_ex_imm11;
  logic [2:0]    ex_wsel, nb_ex_wsel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_pipe #(.DATA_W(DW), .NUM_REGS(8), .LINK_REG(7), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc2(if_pc2),
    .flush(flush), .id_instr(id_instr), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_regwrt(id_regwrt), .id_is_load(id_is_load), .id_zext(id_zext), .id_rd_dst(id_rd_dst),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .stall(stall), .ex_valid(ex_valid),
    .ex_instr(ex_instr), .ex_pc2(ex_pc2), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_wsel(ex_wsel),
    .ex_regwrt(ex_regwrt), .ex_is_load(ex_is_load), .ex_imm5(ex_imm5), .ex_imm8(ex_imm8),
    .ex_imm11(ex_imm11)
  );

  decode_pipe #(.DATA_W(DW), .NUM_REGS(8), .LINK_REG(7), .BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc2(if_pc2),
    .flush(flush), .id_instr(nb_id_instr), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_regwrt(id_regwrt), .id_is_load(id_is_load), .id_zext(id_zext), .id_rd_dst(id_rd_dst),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .stall(nb_stall),
    .ex_valid(nb_ex_valid), .ex_instr(nb_ex_instr), .ex_pc2(nb_ex_pc2), .ex_rd1(nb_ex_rd1),
    .ex_rd2(nb_ex_rd2), .ex_wsel(nb_ex_wsel), .ex_regwrt(nb_ex_regwrt),
    .ex_is_load(nb_ex_is_load), .ex_imm5(nb_ex_imm5), .ex_imm8(nb_ex_imm8),
    .ex_imm11(nb_ex_imm11)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Flush both pipeline stages and idle every control input.
  task automatic clear;
    if_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_regwrt = 0; id_is_load = 0;
    id_zext = 0; id_rd_dst = 2'b00; wb_en = 0;
    flush = 1;
    tick();
    flush = 0;
  endtask

  // Load writing r2 (instr 0x0040, dest = instr[7:5]) ends up in EX, dep in ID.
  task automatic setup_load(input logic [15:0] dep);
    if_valid = 1; if_instr = 16'h0040; if_pc2 = 16'h0042;
    tick();
    id_is_load = 1; id_regwrt = 1; id_rd_dst = 2'b00; id_use_rs1 = 0; id_use_rs2 = 0;
    if_instr = dep; if_pc2 = 16'h0044;
    tick();
    id_is_load = 0; id_regwrt = 1; id_rd_dst = 2'b10; if_valid = 0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ex_valid: got %b want 0", ex_valid); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_checks++; if ({ex_instr, ex_pc2, ex_imm11} !== 48'h0) begin n_fail++; $display("FAIL rst_ex_fields: got %h want 0", {ex_instr, ex_pc2, ex_imm11}); end
    #12 rst = 0;
  endtask

  task automatic test_latency;
    clear();
    if_valid = 1; if_instr = 16'h1C5A; if_pc2 = 16'h0010;
    tick();
    if_valid = 0; id_regwrt = 1; id_rd_dst = 2'b01;
    #1;
    n_checks++; if (id_instr !== 16'h1C5A) begin n_fail++; $display("FAIL lat_id_instr: got %h want 1c5a", id_instr); end
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid: got %b want 0", ex_valid); end
    tick();
    n_checks++; if (ex_valid !== 1'b1 || nb_ex_valid !== 1'b1) begin n_fail++; $display("FAIL lat_ex_valid: got %b/%b want 1/1", ex_valid, nb_ex_valid); end
    n_checks++; if (ex_instr !== 16'h1C5A || ex_pc2 !== 16'h0010) begin n_fail++; $display("FAIL lat_ex_data: got %h %h want 1c5a 0010", ex_instr, ex_pc2); end
    n_checks++; if (ex_wsel !== 3'd4 || ex_regwrt !== 1'b1) begin n_fail++; $display("FAIL lat_wsel: got %0d %b want 4 1", ex_wsel, ex_regwrt); end
  endtask

  task automatic test_bypass;
    clear();
    wb_en = 1; wb_sel = 3'd3; wb_data = 16'h1234;
    if_valid = 1; if_instr = 16'h0300; if_pc2 = 16'h0302;
    tick();
    id_use_rs1 = 1; wb_data = 16'hBEEF; if_valid = 0;
    tick();
    wb_en = 0;
    n_checks++; if (ex_rd1 !== 16'hBEEF) begin n_fail++; $display("FAIL bypass_rd1: got %h want beef", ex_rd1); end
    n_checks++; if (nb_ex_rd1 !== 16'h1234) begin n_fail++; $display("FAIL nobypass_rd1: got %h want 1234", nb_ex_rd1); end
    n_checks++; if (ex_rd2 !== 16'h0000 || ex_pc2 !== 16'h0302) begin n_fail++; $display("FAIL bypass_rd2_pc: got %h %h want 0000 0302", ex_rd2, ex_pc2); end
  endtask

  task automatic test_load_use;
    clear();
    setup_load(16'h0140);
    id_use_rs1 = 0; id_use_rs2 = 1; if_valid = 1; if_instr = 16'hAAAA;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", stall); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_len: got %b want 0", stall); end
    n_checks++; if ({ex_valid, ex_regwrt, ex_is_load} !== 3'b000) begin n_fail++; $display("FAIL lu_bubble: got %b want 000", {ex_valid, ex_regwrt, ex_is_load}); end
    n_checks++; if (id_instr !== 16'h0140) begin n_fail++; $display("FAIL lu_hold: got %h want 0140", id_instr); end
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_instr !== 16'h0140) begin n_fail++; $display("FAIL lu_advance: got %b %h want 1 0140", ex_valid, ex_instr); end
    n_checks++; if (id_instr !== 16'hAAAA) begin n_fail++; $display("FAIL lu_next_id: got %h want aaaa", id_instr); end
  endtask

  task automatic test_no_false_stall;
    clear();
    setup_load(16'h0140);
    id_use_rs1 = 1; id_use_rs2 = 0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL nfs_no_rs2: got %b want 0", stall); end
    clear();
    setup_load(16'h0080);
    id_use_rs1 = 0; id_use_rs2 = 1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL nfs_r4: got %b want 0", stall); end
  endtask

  task automatic test_flush;
    clear();
    setup_load(16'h0140);
    id_use_rs2 = 1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fl_pre_stall: got %b want 1", stall); end
    flush = 1; if_valid = 1; if_instr = 16'h1234;
    tick();
    flush = 0; if_valid = 0;
    n_checks++; if (ex_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL fl_after: got %b %b want 0 0", ex_valid, stall); end
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_regwrt !== 1'b0) begin n_fail++; $display("FAIL fl_id_killed: got %b %b want 0 0", ex_valid, ex_regwrt); end
  endtask

  task automatic test_back_to_back_imm;
    clear();
    if_valid = 1; if_instr = 16'h0593; if_pc2 = 16'h0100;
    tick();
    id_zext = 0; id_rd_dst = 2'b11; id_regwrt = 1;
    tick();
    n_checks++; if (ex_imm5 !== 16'hFFF3 || ex_imm8 !== 16'hFF93) begin n_fail++; $display("FAIL imm_sext: got %h %h want fff3 ff93", ex_imm5, ex_imm8); end
    n_checks++; if (ex_imm11 !== 16'hFD93) begin n_fail++; $display("FAIL imm11_s: got %h want fd93", ex_imm11); end
    n_checks++; if (ex_wsel !== 3'd7) begin n_fail++; $display("FAIL imm_link: got %0d want 7", ex_wsel); end
    id_zext = 1; if_valid = 0;
    tick();
    n_checks++; if (ex_imm5 !== 16'h0013 || ex_imm8 !== 16'h0093) begin n_fail++; $display("FAIL imm_zext: got %h %h want 0013 0093", ex_imm5, ex_imm8); end
    n_checks++; if (ex_imm11 !== 16'hFD93 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL imm11_z: got %h %b want fd93 1", ex_imm11, ex_valid); end
  endtask

  task automatic test_reset_mid_stall;
    clear();
    setup_load(16'h0140);
    id_use_rs2 = 1;
    #1;
    n_checks++; if (stall !== 1'b1 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got %b %b want 1 1", stall, ex_valid); end
    rst = 1;
    #1;
    n_checks++; if ({stall, ex_valid, ex_regwrt, ex_is_load} !== 4'b0000) begin n_fail++; $display("FAIL rm_ctrl: got %b want 0000", {stall, ex_valid, ex_regwrt, ex_is_load}); end
    n_checks++; if ({ex_instr, ex_pc2, ex_wsel} !== 35'h0) begin n_fail++; $display("FAIL rm_data: got %h want 0", {ex_instr, ex_pc2, ex_wsel}); end
    #1 rst = 0;
    id_use_rs1 = 1; id_use_rs2 = 0; id_regwrt = 0; id_rd_dst = 2'b00;
    if_valid = 1; if_instr = 16'h0300; if_pc2 = 16'h0500;
    tick();
    if_valid = 0;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rm_one_clk: got %b want 0", ex_valid); end
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_pc2 !== 16'h0500) begin n_fail++; $display("FAIL rm_two_clk: got %b %h want 1 0500", ex_valid, ex_pc2); end
    n_checks++; if (ex_rd1 !== 16'h0000) begin n_fail++; $display("FAIL rm_regfile: got %h want 0000", ex_rd1); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bypass();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_back_to_back_imm();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
Parametrised pipelined decode stage for the 16-bit five-stage core, successor to the single-cycle decode block.
- Contains the IF/ID pipeline register, the register file with write-through bypass, a load-use hazard interlock, flush handling, and the ID/EX pipeline register.
- The existing control decoder is instantiated by the parent on id_instr. Its outputs feed back in as id_* inputs.
- Latency from if_instr to ex_* is 2 clocks when there is no stall.

Parameters:
- DATA_W, 16: datapath and register width. Immediates are extended to DATA_W. Must be >= 16.
- NUM_REGS, 8: register count. Fixed to 8 by the 3-bit ISA register fields; the parameter exists for the check only.
- LINK_REG, 7: write register used when id_rd_dst = 2'b11.
- BYPASS, 1: when 1, a same-cycle writeback to a read register is forwarded to the read data. When 0, the old value is read.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_valid  in  1  fetch slot valid
- if_instr  in  16  fetched instruction
- if_pc2  in  DATA_W  PC+2 of fetched instruction
- flush  in  1  branch/jump redirect from EX; kills IF/ID and ID/EX contents
- id_instr  out  16  instruction in ID, to the parent's control decoder
- id_use_rs1  in  1  ID instruction reads [10:8]
- id_use_rs2  in  1  ID instruction reads [7:5]
- id_regwrt  in  1  ID instruction writes a register
- id_is_load  in  1  ID instruction is a load
- id_zext  in  1  zero-extend imm5/imm8
- id_rd_dst  in  2  destination select: 00=[7:5], 01=[10:8], 10=[4:2], 11=LINK_REG
- wb_en  in  1  writeback enable
- wb_sel  in  3  writeback register
- wb_data  in  DATA_W  writeback data
- stall  out  1  load-use interlock active; fetch must hold PC
- ex_valid  out  1  ID/EX slot valid
- ex_instr  out  16  registered instruction
- ex_pc2  out  DATA_W  registered PC+2
- ex_rd1  out  DATA_W  registered rs1 data
- ex_rd2  out  DATA_W  registered rs2 data
- ex_wsel  out  3  registered destination register
- ex_regwrt  out  1  registered write enable, gated by validity
- ex_is_load  out  1  registered load flag, gated by validity
- ex_imm5  out  DATA_W  registered imm5, extended
- ex_imm8  out  DATA_W  registered imm8, extended
- ex_imm11  out  DATA_W  registered imm11, always sign-extended

Behaviour:
- Reset (rst=1, async, active-high):
  - All registers and all ex_* outputs go to 0. IF/ID valid=0.
  - Takes effect immediately, including mid-stall; the next cycle starts empty.
- Regfile:
  - Written on posedge clk when wb_en=1. Writes are not gated by stall or flush.
  - Reads are combinational on id_instr[10:8] and [7:5].
- Bypass (BYPASS=1): if wb_en and wb_sel equals a read index, that read returns wb_data in the same cycle.
- Hazard:
  - stall = id_valid & ex_valid & ex_is_load & ex_regwrt & ((id_use_rs1 & ex_wsel==id_instr[10:8]) | (id_use_rs2 & ex_wsel==id_instr[7:5])).
  - Hazard detection is load-use only; ALU forwarding is EX's job.
- Per-clock update priority: flush > stall > advance.
  - flush=1: IF/ID valid<=0 and ID/EX valid<=0. stall is ignored.
  - stall=1: IF/ID holds. ID/EX loads a bubble (ex_valid=0, ex_regwrt=0, ex_is_load=0; data fields don't-care but driven 0).
  - advance: IF/ID<={if_valid,if_instr,if_pc2}. ID/EX<=decoded ID contents, with valid=id_valid.
- Validity gating: ex_regwrt and ex_is_load are 0 whenever ex_valid=0.
- Stall duration: a stall lasts exactly 1 cycle, because the bubble clears ex_is_load.
- Immediate extension:
  - imm5 = instr[4:0]; imm8 = instr[7:0]. Both are sign- or zero-extended per id_zext.
  - imm11 = instr[10:0], always sign-extended.
- Elaboration: NUM_REGS != 8 or DATA_W < 16 must raise an elaboration error.

Decomposition:
- Package decode_pkg: REG_AW=3, the RD_DST encodings (RD_RT, RD_RS, RD_RD, RD_LINK), and instruction field position constants.
- One sub-module: decode_regfile (async-reset register array with the BYPASS option).
- Hazard logic and pipeline registers stay in the top module.

Test Plan:
- Reset: assert rst mid-stream with ex_valid=1 -> all ex_* and stall read 0 immediately, before any clock edge; the first instruction after release reaches ex_valid 2 clocks after it is presented.
- Bypass: write wb_sel=3, wb_data=16'hBEEF while ID reads rs1=3 -> ex_rd1=16'hBEEF next clock. With BYPASS=0 -> the old value is captured.
- Load-use: a load to r2 in EX, with ID reading r2 via rs2 -> stall=1 for exactly 1 cycle, ex_valid=0 bubble, then the dependent instruction advances with ex_valid=1.
- No false stall: a load to r2 in EX with ID id_use_rs2=0, or ID reading r4 -> stall=0.
- Flush priority: flush=1 in the same cycle as stall=1 -> the next cycle has IF/ID valid=0, ex_valid=0, stall=0.
- Immediates: instr[4:0]=5'b10011 -> ex_imm5=16'hFFF3 with id_zext=0 and 16'h0013 with id_zext=1; id_rd_dst=11 -> ex_wsel=7.
